ram_loader: RTL and testbench

- Bus-side program loader: the writing end of the RAM/MAR interface on the shared 8-bit bus.
- Accepts a byte stream over a valid/ready handshake, e.g. from a serial receiver.
- Writes the bytes into consecutive RAM words 0..WORDS-1.
- Uses the same two bus transactions the control unit issues: MAR load (MI), then RAM write (RI).
- Holds busy high throughout so the CPU control word can be gated off the bus while loading.

---
 rtl/ram_loader.sv | 138 +++++++++++++
 tb/tb_ram_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: bus-side program loader. It takes a byte stream over a
// valid/ready handshake and writes it into RAM words 0..WORDS-1. Each word
// uses the same two bus transactions the control unit issues: a MAR load
// (MI) followed by a RAM write (RI). While a session is in progress, busy
// stays high so the CPU control word can be gated off the shared bus.
module ram_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  inout  wire  [7:0]        bus,
  output logic              MI,
  output logic              RI,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_q, data_nxt;
  logic              bus_en;
  logic [7:0]        bus_out;

  // State, address and captured byte registers; clr is synchronous and has top priority.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (clr) begin
      state  <= IDLE;
      addr   <= '0;
      // NOTE: the byte register is cleared on reset, but the RAM behind the
      // bus is not; words already written survive a reset.
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      data_q <= data_nxt;
    end
  end

  // Next-state logic and Moore outputs; abort outranks the normal transitions.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    addr_nxt  = addr;
    data_nxt  = data_q;
    in_ready  = 1'b0;
    MI        = 1'b0;
    RI        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    bus_en    = 1'b0;
    bus_out   = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_BYTE;
          addr_nxt  = '0;
        end
      end

      WAIT_BYTE: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          addr_nxt  = '0;
        end else if (in_valid) begin
          data_nxt  = in_data;
          state_nxt = ADDR;
        end
      end

      ADDR: begin
        busy    = 1'b1;
        MI      = 1'b1;
        bus_en  = 1'b1;
        bus_out = 8'(addr);
        if (abort) begin
          state_nxt = IDLE;
          addr_nxt  = '0;
        end else begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        // The RAM write lands on the closing edge even when abort is high.
        busy    = 1'b1;
        RI      = 1'b1;
        bus_en  = 1'b1;
        bus_out = data_q;
        if (abort) begin
          state_nxt = IDLE;
          addr_nxt  = '0;
        end else if (addr == LAST_ADDR) begin
          state_nxt = DONE;
        end else begin
          addr_nxt  = addr + ADDR_W'(1);
          state_nxt = WAIT_BYTE;
        end
      end

      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        addr_nxt  = '0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  // The loader drives the shared bus only during ADDR and DATA cycles.
  assign bus = bus_en ? bus_out : 'z;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader. A RAM/MAR model sits on
// the bus, and the stimulus side pushes the expected writes and done
// cycles into queues. A monitor running on the falling edge pops those
// entries and compares them against what the loader presents. Pull-ups
// make a released bus read as 0xFF.
module tb_ram_loader;

  localparam int WORDS  = 16;
  localparam int ADDR_W = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, MI, RI, busy, done;
  logic [ADDR_W-1:0] addr;
  wire  [7:0] bus;

  // Second instance used only for the WORDS=4 session.
  logic start4 = 1'b0;
  logic in_valid4 = 1'b0;
  logic [7:0] in_data4 = 8'h00;
  logic in_ready4, MI4, RI4, busy4, done4;
  logic [1:0] addr4;
  wire  [7:0] bus4;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (bus[g]);
    pullup (bus4[g]);
  end

  ram_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bus(bus), .MI(MI), .RI(RI), .busy(busy), .done(done), .addr(addr)
  );

  ram_loader #(.WORDS(4), .ADDR_W(2)) u_dut4 (
    .clk(clk), .clr(clr), .start(start4), .abort(1'b0),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .bus(bus4), .MI(MI4), .RI(RI4), .busy(busy4), .done(done4), .addr(addr4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  wr_t  exp_q[$];
  int   done_q[$];
  logic [7:0] ram[WORDS];      // RAM contents as written over the bus
  logic [7:0] ram_exp[WORDS];  // reference: last byte handed over per word
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] wr_addr;
  int   last_accept;
  int   first_accept;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: models MAR/RAM and checks every bus transaction against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mi_ri_exclusive", MI & RI, 0);
      if (!MI && !RI) check("bus_released", bus, 8'hFF);
      if (MI) begin
        mar = bus[ADDR_W-1:0];
        if (exp_q.size() == 0) check("mi_unexpected", MI, 0);
        else begin
          check("mi_bus", bus, 8'(exp_q[0].addr));
          check("mi_addr", addr, exp_q[0].addr);
        end
      end
      if (RI) begin
        ram[mar] = bus;
        if (exp_q.size() == 0) check("ri_unexpected", RI, 0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          check("ri_data", bus, e.data);
          check("ri_addr", addr, e.addr);
        end
      end
      if (done) begin
        check("done_busy", busy, 1);
        if (done_q.size() == 0) check("done_unexpected", done, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
  endtask

  // Present one byte after `gap` idle cycles in WAIT_BYTE; called and returns on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit last);
    in_valid = 1'b0;
    wait_ready();
    repeat (gap) begin
      check("gap_ready", in_ready, 1);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    last_accept = cyc;
    exp_q.push_back('{addr: wr_addr, data: b});
    ram_exp[wr_addr] = b;
    // Accept cycle, ADDR, DATA, then the done cycle.
    if (last) done_q.push_back(cyc + 3);
    wr_addr++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_addr = '0;
  endtask

  task automatic wait_done(output int done_cyc);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    done_cyc = cyc;
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_after_done", busy, 0);
    check("addr_after_done", addr, 0);
    check("done_queue_empty", done_q.size(), 0);
  endtask

  task automatic readback();
    for (int i = 0; i < WORDS; i++)
      check($sformatf("ram_word_%0d", i), ram[i], ram_exp[i]);
  endtask

  // Global time limit so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int n;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = 8'h5A;
      ram_exp[i] = 8'h5A;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mi", MI, 0);
    check("rst_ri", RI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr, 0);
    check("rst_bus", bus, 8'hFF);
    check("rst4_busy", busy4, 0);
    check("rst4_bus", bus4, 8'hFF);
    clr = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Full load 0x10..0x1F with no source stalls
    start_session();
    for (int i = 0; i < WORDS; i++) begin
      send_byte(8'(8'h10 + i), 0, i == WORDS - 1);
      if (i == 0) first_accept = last_accept;
    end
    wait_done(dc);
    // Counting the first accept cycle as cycle 1, done is cycle 3*WORDS+1.
    check("done_latency", dc - first_accept + 1, 3 * WORDS + 1);
    readback();

    // Stalled source: five idle cycles in front of every byte, random data
    start_session();
    for (int i = 0; i < WORDS; i++) send_byte(8'($urandom), 5, i == WORDS - 1);
    wait_done(dc);
    readback();

    // Abort in the WAIT_BYTE that follows the sixth byte
    start_session();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), $urandom_range(0, 2), 1'b0);
    wait_ready();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_addr", addr, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_no_done", done, 0);
    repeat (3) @(negedge clk);
    readback();

    // Abort during DATA: that write still completes
    start_session();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, 1'b0);
    @(negedge clk);
    check("abort_data_ri", RI, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_data_busy", busy, 0);
    check("abort_data_addr", addr, 0);
    repeat (2) @(negedge clk);
    readback();

    // Reset during an ADDR cycle, then reload from address 0
    start_session();
    for (int i = 0; i < 2; i++) send_byte(8'($urandom), 0, 1'b0);
    wait_ready();
    in_data  = 8'hC3;
    in_valid = 1'b1;
    exp_q.push_back('{addr: wr_addr, data: 8'hC3});
    @(negedge clk);
    in_valid = 1'b0;
    check("clr_in_addr_mi", MI, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_mi", MI, 0);
    check("clr_ri", RI, 0);
    check("clr_bus", bus, 8'hFF);
    check("clr_busy", busy, 0);
    check("clr_addr", addr, 0);
    exp_q.delete();
    @(negedge clk);
    start_session();
    for (int i = 0; i < WORDS; i++) send_byte(8'($urandom), 0, i == WORDS - 1);
    wait_done(dc);
    readback();

    // in_valid while idle is ignored; start while busy is ignored
    in_data  = 8'hEE;
    in_valid = 1'b1;
    repeat (3) begin
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start_session();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1, 1'b0);
    wait_ready();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy_addr", addr, 3);
    check("start_busy_ready", in_ready, 1);
    send_byte(8'($urandom), 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy_addr_data", addr, 3);
    for (int i = 4; i < WORDS; i++) send_byte(8'($urandom), $urandom_range(0, 3), i == WORDS - 1);
    wait_done(dc);
    readback();

    // WORDS=4 instance: feed 0xA0..0xA3
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!in_ready4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("p4_ready", in_ready4, 1);
      check("p4_no_early_done", done4, 0);
      in_data4  = 8'(8'hA0 + i);
      in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      check("p4_mi", MI4, 1);
      check("p4_mi_bus", bus4, i);
      check("p4_addr", addr4, i);
      @(negedge clk);
      check("p4_ri", RI4, 1);
      check("p4_ri_bus", bus4, 8'hA0 + i);
    end
    @(negedge clk);
    check("p4_done", done4, 1);
    @(negedge clk);
    check("p4_done_single", done4, 0);
    check("p4_busy_after", busy4, 0);
    check("p4_addr_after", addr4, 0);

    repeat (2) @(negedge clk);
    check("final_exp_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
